// File: rtl/param_sequence_detector.sv
// Serial bit-pattern detector with a runtime-loadable pattern, overlap/non-overlap modes and a saturating match count.
// found is registered: it pulses in the cycle after the edge that samples the last pattern bit. There is no backpressure.
module param_sequence_detector #(
  parameter int                     PATTERN_LEN     = 4,
  parameter logic [PATTERN_LEN-1:0] DEFAULT_PATTERN = 4'b0110,
  parameter int                     COUNT_W         = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   x,
  input  logic                   x_valid,
  input  logic                   overlap,
  input  logic [PATTERN_LEN-1:0] pattern_in,
  input  logic                   pattern_load,
  input  logic                   count_clear,
  output logic                   found,
  output logic [COUNT_W-1:0]     match_count,
  output logic [PATTERN_LEN-1:0] pattern
);

  localparam int                FILL_W    = $clog2(PATTERN_LEN + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PATTERN_LEN);
  localparam logic [FILL_W-1:0] FILL_ARM  = FILL_W'(PATTERN_LEN - 1);

  logic [PATTERN_LEN-1:0] pattern_q, pattern_d;
  logic [PATTERN_LEN-1:0] history_q, history_d;
  logic [FILL_W-1:0]      fill_q, fill_d;
  logic                   found_q, found_d;
  logic [COUNT_W-1:0]     count_q, count_d;
  logic [PATTERN_LEN-1:0] candidate;
  logic                   match;

  assign candidate = {history_q[PATTERN_LEN-2:0], x};

  always_comb begin
    pattern_d = pattern_q;
    history_d = history_q;
    fill_d    = fill_q;
    found_d   = 1'b0;
    match     = 1'b0;
    count_d   = count_q;

    if (pattern_load) begin
      pattern_d = pattern_in;
      history_d = '0;
      fill_d    = '0;
    end else if (x_valid) begin
      // fill gating keeps the zeroed history from matching an all-zero pattern
      match     = (candidate == pattern_q) && (fill_q >= FILL_ARM);
      history_d = candidate;
      found_d   = match;
      if (match && !overlap) begin
        fill_d = '0;
      end else if (fill_q != FILL_FULL) begin
        fill_d = fill_q + 1'b1;
      end
    end

    if (count_clear) begin
      count_d = '0;
    end else if (match && (count_q != {COUNT_W{1'b1}})) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pattern_q <= DEFAULT_PATTERN;
      history_q <= '0;
      fill_q    <= '0;
      found_q   <= 1'b0;
      count_q   <= '0;
    end else begin
      pattern_q <= pattern_d;
      history_q <= history_d;
      fill_q    <= fill_d;
      found_q   <= found_d;
      count_q   <= count_d;
    end
  end

  assign found       = found_q;
  assign match_count = count_q;
  assign pattern     = pattern_q;

endmodule

// File: tb/tb_param_sequence_detector.sv
// Directed bench for param_sequence_detector: a bit-queue reference model feeds a scoreboard of expected outputs per edge.
module tb_param_sequence_detector;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       x = 1'b0, x_valid = 1'b0, overlap = 1'b1;
  logic [3:0] pattern_in = 4'b0000;
  logic       pattern_load = 1'b0, count_clear = 1'b0;
  logic       found, found2;
  logic [7:0] match_count;
  logic [1:0] match_count2;
  logic [3:0] pattern, pattern2;

  param_sequence_detector #(.PATTERN_LEN(4), .DEFAULT_PATTERN(4'b0110), .COUNT_W(8)) dut (
    .clock(clock), .reset(reset), .x(x), .x_valid(x_valid), .overlap(overlap),
    .pattern_in(pattern_in), .pattern_load(pattern_load), .count_clear(count_clear),
    .found(found), .match_count(match_count), .pattern(pattern)
  );

  param_sequence_detector #(.PATTERN_LEN(4), .DEFAULT_PATTERN(4'b0110), .COUNT_W(2)) dut2 (
    .clock(clock), .reset(reset), .x(x), .x_valid(x_valid), .overlap(overlap),
    .pattern_in(pattern_in), .pattern_load(pattern_load), .count_clear(count_clear),
    .found(found2), .match_count(match_count2), .pattern(pattern2)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       f;
    logic [7:0] c8;
    logic [1:0] c2;
    logic [3:0] p;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  logic       m_bits[$];
  logic [3:0] m_pat;
  logic [7:0] m_c8;
  logic [1:0] m_c2;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_bits.delete();
    m_pat = 4'b0110;
    m_c8  = 8'd0;
    m_c2  = 2'd0;
  endtask

  // Model keeps the raw valid bits since the last restart and compares the newest four
  task automatic model_edge(input logic xb, input logic vld, input logic ovl, input logic ld,
                            input logic [3:0] pin, input logic clr, output exp_t e);
    logic       m;
    logic [3:0] v;
    m = 1'b0;
    if (ld) begin
      m_pat = pin;
      m_bits.delete();
    end else if (vld) begin
      m_bits.push_back(xb);
      if (m_bits.size() > 4) void'(m_bits.pop_front());
      if (m_bits.size() == 4) begin
        v = 4'b0000;
        for (int i = 0; i < 4; i++) v = {v[2:0], m_bits[i]};
        m = (v == m_pat);
      end
      if (m && !ovl) m_bits.delete();
    end
    if (clr) begin
      m_c8 = 8'd0;
      m_c2 = 2'd0;
    end else if (m) begin
      if (m_c8 != 8'hFF) m_c8 = m_c8 + 8'd1;
      if (m_c2 != 2'd3)  m_c2 = m_c2 + 2'd1;
    end
    e.f  = m;
    e.c8 = m_c8;
    e.c2 = m_c2;
    e.p  = m_pat;
  endtask

  task automatic step(input logic xb, input logic vld, input logic ovl, input logic ld,
                      input logic [3:0] pin, input logic clr, input string tag);
    exp_t e;
    @(negedge clock);
    x = xb; x_valid = vld; overlap = ovl;
    pattern_load = ld; pattern_in = pin; count_clear = clr;
    model_edge(xb, vld, ovl, ld, pin, clr, e);
    sb.push_back(e);
    @(posedge clock);
    #1;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk({tag, "_found"}, 32'(found), 32'(e.f));
      chk({tag, "_count"}, 32'(match_count), 32'(e.c8));
      chk({tag, "_count2"}, 32'(match_count2), 32'(e.c2));
      chk({tag, "_pattern"}, 32'(pattern), 32'(e.p));
    end
  endtask

  initial begin
    logic [3:0] s;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    chk("rst_found", 32'(found), 32'd0);
    chk("rst_count", 32'(match_count), 32'd0);
    chk("rst_pattern", 32'(pattern), 32'h6);
    @(negedge clock);
    reset = 1'b0;

    // default pattern 0110, overlap
    s = 4'b0110;
    for (int i = 3; i >= 0; i--) step(s[i], 1'b1, 1'b1, 1'b0, 4'h0, 1'b0, "dflt");
    chk("dflt_found_end", 32'(found), 32'd1);
    chk("dflt_count_end", 32'(match_count), 32'd1);
    step(1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0, "dflt_idle");
    chk("dflt_pulse_once", 32'(found), 32'd0);

    // 0101 overlapping then non-overlapping on 010101
    for (int pass = 0; pass < 2; pass++) begin
      step(1'b1, 1'b1, 1'b1, 1'b1, 4'b0101, 1'b1, "load0101");
      for (int i = 0; i < 6; i++)
        step(logic'(i % 2), 1'b1, logic'(pass == 0), 1'b0, 4'h0, 1'b0, pass == 0 ? "ovl" : "novl");
      chk(pass == 0 ? "ovl_count" : "novl_count", 32'(match_count), pass == 0 ? 32'd2 : 32'd1);
    end

    // all-zero pattern must not match the reset-zero history early
    step(1'b0, 1'b0, 1'b1, 1'b1, 4'b0000, 1'b1, "load0000");
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0, "zero_gate");
    chk("zero_gate_nofound", 32'(found), 32'd0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0, "zero_4th");
    chk("zero_4th_found", 32'(found), 32'd1);

    // valid gaps between bits
    step(1'b0, 1'b0, 1'b1, 1'b1, 4'b0110, 1'b1, "load0110");
    step(1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0, "gap_b0");
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0, "gap");
    step(1'b1, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0, "gap_b1");
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0, "gap");
    step(1'b1, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0, "gap_b2");
    step(1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0, "gap_b3");
    chk("gap_found", 32'(found), 32'd1);

    // saturation with all-ones pattern; load also ignores a valid x
    step(1'b1, 1'b1, 1'b1, 1'b1, 4'b1111, 1'b1, "load1111");
    for (int i = 0; i < 9; i++) step(1'b1, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0, "ones");
    chk("sat_count2", 32'(match_count2), 32'd3);
    chk("sat_count8", 32'(match_count), 32'd6);
    step(1'b1, 1'b1, 1'b1, 1'b0, 4'h0, 1'b1, "clr_vs_match");
    chk("clr_wins_found", 32'(found), 32'd1);
    chk("clr_wins_count", 32'(match_count), 32'd0);

    // async reset mid-stream
    step(1'b0, 1'b0, 1'b1, 1'b1, 4'b1001, 1'b1, "load1001");
    s = 4'b1001;
    for (int i = 3; i >= 0; i--) step(s[i], 1'b1, 1'b1, 1'b0, 4'h0, 1'b0, "pre_rst");
    s = 4'b0011;
    for (int i = 2; i >= 0; i--) step(s[i], 1'b1, 1'b1, 1'b0, 4'h0, 1'b0, "pre_rst");
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    chk("arst_found", 32'(found), 32'd0);
    chk("arst_count", 32'(match_count), 32'd0);
    chk("arst_pattern", 32'(pattern), 32'h6);
    @(negedge clock);
    reset = 1'b0;
    step(1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0, "post_rst_0");
    chk("post_rst_nofound", 32'(found), 32'd0);
    s = 4'b0110;
    for (int i = 3; i >= 0; i--) step(s[i], 1'b1, 1'b1, 1'b0, 4'h0, 1'b0, "post_rst");
    chk("post_rst_found", 32'(found), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
